// File: rtl/crc_pkg.sv
// ---------------------------------------------------------------------------
// crc_pkg
//
// Shared definitions for the streaming CRC engine:
//   - crc_state_e           : engine state encoding (IDLE / BUSY / DONE)
//   - CRC32_POLY_REFL       : reflected CRC-32 (IEEE 802.3) generator
//   - CRC16_CCITT_POLY_REFL : reflected CRC-16/CCITT generator
//   - bpc_divides()         : elaboration-time check that the bits folded
//                             per cycle split a message word evenly
// ---------------------------------------------------------------------------
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } crc_state_e;

    localparam logic [31:0] CRC32_POLY_REFL       = 32'hEDB8_8320;
    localparam logic [15:0] CRC16_CCITT_POLY_REFL = 16'h8408;

    // True when bpc is a non-zero divisor of data_w, i.e. a word breaks into
    // a whole number of fold chunks.
    function automatic bit bpc_divides(input int data_w, input int bpc);
        return (bpc > 0) && (bpc <= data_w) && ((data_w % bpc) == 0);
    endfunction

endpackage

// File: rtl/crc_fold_step.sv
// ---------------------------------------------------------------------------
// crc_fold_step
//
// Purely combinational fold of BPC message bits into a reflected (LSB-first)
// CRC register. Bit data_in[0] is applied first.
//
// Parameters:
//   CRC_W   CRC register width
//   POLY    reflected generator polynomial, CRC_W bits
//   BPC     number of message bits folded in one step
//
// Ports:
//   crc_in   [CRC_W-1:0]  register value before the fold
//   data_in  [BPC-1:0]    message bits, LSB applied first
//   crc_out  [CRC_W-1:0]  register value after all BPC bits are applied
// ---------------------------------------------------------------------------
module crc_fold_step
    import crc_pkg::*;
#(
    parameter int                 CRC_W = 32,
    parameter logic [CRC_W-1:0]   POLY  = CRC_W'(CRC32_POLY_REFL),
    parameter int                 BPC   = 1
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic [BPC-1:0]   data_in,
    output logic [CRC_W-1:0] crc_out
);

    logic [CRC_W-1:0] acc;

    // Unrolled chain of single-bit LFSR steps: the feedback bit is the
    // register LSB XOR the incoming message bit, and a set feedback bit
    // XORs the polynomial into the right-shifted register.
    always_comb begin
        acc = crc_in;
        for (int i = 0; i < BPC; i++) begin
            if (acc[0] ^ data_in[i]) begin
                acc = (acc >> 1) ^ POLY;
            end else begin
                acc = acc >> 1;
            end
        end
        crc_out = acc;
    end

endmodule

// File: rtl/crc_stream_engine.sv
// ---------------------------------------------------------------------------
// crc_stream_engine
//
// Streaming CRC engine. Message words arrive under a valid/ready handshake
// with an end-of-message marker; each word is folded BPC bits per cycle into
// a running CRC register, and the finished CRC (register ^ XOROUT) is
// returned under a second valid/ready handshake.
//
// Parameters:
//   CRC_W   CRC register width (8..64)
//   POLY    reflected generator polynomial
//   INIT    register value at the start of every message
//   XOROUT  value XORed into the register to form the result
//   DATA_W  message word width
//   BPC     bits folded per cycle; must divide DATA_W
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   input word valid
//   in_ready   engine accepts a word this cycle (from state only)
//   in_data    message word, consumed LSB first
//   in_last    word is the final word of its message
//   out_valid  registered result valid, held until accepted
//   out_ready  consumer accepts the result
//   out_crc    registered final CRC
// ---------------------------------------------------------------------------
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int                 CRC_W  = 32,
    parameter logic [CRC_W-1:0]   POLY   = CRC_W'(CRC32_POLY_REFL),
    parameter logic [CRC_W-1:0]   INIT   = '1,
    parameter logic [CRC_W-1:0]   XOROUT = '1,
    parameter int                 DATA_W = 8,
    parameter int                 BPC    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CRC_W-1:0]  out_crc
);

    localparam int N     = DATA_W / BPC;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    if (!bpc_divides(DATA_W, BPC)) begin : g_bad_bpc
        $error("crc_stream_engine: BPC must divide DATA_W");
    end

    if ((CRC_W < 8) || (CRC_W > 64)) begin : g_bad_width
        $error("crc_stream_engine: CRC_W must be in 8..64");
    end

    crc_state_e        state_q, state_d;
    logic [CRC_W-1:0]  crc_q, crc_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              msg_active_q, msg_active_d;
    logic              out_valid_q, out_valid_d;
    logic [CRC_W-1:0]  out_crc_q, out_crc_d;

    logic [CRC_W-1:0]  crc_fold;
    logic              last_chunk;
    logic              accept;

    crc_fold_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .BPC   (BPC)
    ) u_fold (
        .crc_in  (crc_q),
        .data_in (shift_q[BPC-1:0]),
        .crc_out (crc_fold)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            crc_q        <= INIT;
            shift_q      <= '0;
            cnt_q        <= '0;
            last_q       <= 1'b0;
            msg_active_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_crc_q    <= '0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            msg_active_q <= msg_active_d;
            out_valid_q  <= out_valid_d;
            out_crc_q    <= out_crc_d;
        end
    end

    // Next-state and datapath logic. in_ready depends only on registered
    // state so it never combinationally follows in_valid. While the final
    // chunk of a non-final word is folding, a new word may be accepted in
    // the same cycle, which keeps back-to-back words at one per N cycles.
    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        msg_active_d = msg_active_q;
        out_valid_d  = out_valid_q;
        out_crc_d    = out_crc_q;

        last_chunk = (cnt_q == CNT_LAST);

        in_ready = 1'b0;
        unique case (state_q)
            IDLE:    in_ready = 1'b1;
            BUSY:    in_ready = last_chunk && !last_q;
            DONE:    in_ready = 1'b0;
            default: in_ready = 1'b0;
        endcase

        accept = in_valid && in_ready;

        unique case (state_q)
            IDLE: begin
                // Outside a message the register must sit at INIT; inside
                // one (word gap) the running CRC is kept.
                if (!msg_active_q) begin
                    crc_d = INIT;
                end
                if (accept) begin
                    shift_d      = in_data;
                    last_d       = in_last;
                    cnt_d        = '0;
                    msg_active_d = 1'b1;
                    state_d      = BUSY;
                end
            end

            BUSY: begin
                crc_d   = crc_fold;
                shift_d = shift_q >> BPC;
                cnt_d   = cnt_q + 1'b1;
                if (last_chunk) begin
                    cnt_d = '0;
                    if (last_q) begin
                        out_crc_d    = crc_fold ^ XOROUT;
                        out_valid_d  = 1'b1;
                        msg_active_d = 1'b0;
                        state_d      = DONE;
                    end else if (accept) begin
                        shift_d = in_data;
                        last_d  = in_last;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    crc_d       = INIT;
                    last_d      = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_crc   = out_crc_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// ---------------------------------------------------------------------------
// tb_crc_stream_engine
//
// Self-checking bench for crc_stream_engine. Two engines share the clock and
// reset: dut0 uses the defaults (CRC-32, bit-serial), dut1 folds a whole byte
// per cycle. Expected CRCs are queued when a message is driven and popped by
// a per-engine monitor on each output handshake.
// ---------------------------------------------------------------------------
module tb_crc_stream_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [7:0]  in_data   [2];
    logic        in_last   [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_crc   [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    crc_stream_engine dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_data   (in_data[0]),
        .in_last   (in_last[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_crc   (out_crc[0])
    );

    crc_stream_engine #(
        .BPC (8)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_data   (in_data[1]),
        .in_last   (in_last[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_crc   (out_crc[1])
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void pushExp(input int d, input logic [31:0] v);
        if (d == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endfunction

    function automatic int expSize(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [31:0] popExp(input int d);
        if (d == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    // Reference CRC-32 (reflected, init all ones, final xor all ones).
    function automatic logic [31:0] crcModel(input logic [7:0] msg [$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (msg[i]) begin
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ msg[i][b]) c = (c >> 1) ^ 32'hEDB8_8320;
                else                  c = c >> 1;
            end
        end
        return c ^ 32'hFFFF_FFFF;
    endfunction

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one word and hold it until accepted; returns the accept cycle.
    task automatic applyStimulus(input int d, input logic [7:0] data, input logic last,
                                 output int acc_cyc);
        logic hs;
        int   budget;
        budget = 200;
        hs     = 1'b0;
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        in_last[d]  = last;
        do begin
            @(negedge clk);
            hs = in_ready[d];
            @(posedge clk);
            budget--;
        end while (!hs && budget > 0);
        #1;
        in_valid[d] = 1'b0;
        acc_cyc = cyc;
        checkOutput($sformatf("accept%0d", d), {63'd0, hs}, 64'd1);
    endtask

    task automatic sendMessage(input int d, input logic [7:0] msg [$], input int gap_max,
                               output int first_acc, output int last_acc);
        int acc;
        first_acc = 0;
        last_acc  = 0;
        foreach (msg[i]) begin
            if (gap_max > 0) idleCycles($urandom_range(0, gap_max));
            applyStimulus(d, msg[i], (i == msg.size() - 1), acc);
            if (i == 0) first_acc = acc;
            last_acc = acc;
        end
    endtask

    task automatic waitDrain(input int d);
        int budget;
        budget = 500;
        while (expSize(d) != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput($sformatf("drain%0d", d), 64'(expSize(d)), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s_in_ready%0d", tag, d), {63'd0, in_ready[d]}, 64'd1);
            checkOutput($sformatf("%s_out_valid%0d", tag, d), {63'd0, out_valid[d]}, 64'd0);
            checkOutput($sformatf("%s_out_crc%0d", tag, d), {32'd0, out_crc[d]}, 64'd0);
        end
    endtask

    // Output monitors: compare each accepted result with the scoreboard,
    // require a stable result while stalled, and in_ready low while a
    // result is pending.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        initial begin
            logic [31:0] held;
            logic        holding;
            logic [31:0] expv;
            holding = 1'b0;
            held    = '0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    holding = 1'b0;
                end else if (out_valid[g]) begin
                    checkOutput($sformatf("done_in_ready%0d", g), {63'd0, in_ready[g]}, 64'd0);
                    if (holding) checkOutput($sformatf("hold_crc%0d", g), {32'd0, out_crc[g]}, {32'd0, held});
                    if (out_ready[g]) begin
                        checkOutput($sformatf("exp_avail%0d", g), {63'd0, expSize(g) > 0}, 64'd1);
                        if (expSize(g) > 0) begin
                            expv = popExp(g);
                            checkOutput($sformatf("crc%0d", g), {32'd0, out_crc[g]}, {32'd0, expv});
                        end
                        holding = 1'b0;
                    end else begin
                        held    = out_crc[g];
                        holding = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] msg9 [$];
        logic [7:0] rmsg [$];
        logic [7:0] part [$];
        int first, last, acc;

        msg9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            in_last[d]   = 1'b0;
            out_ready[d] = 1'b1;
        end
        idleCycles(3);
        rst = 1'b0;
        @(negedge clk);
        checkResetValues("reset");
        @(posedge clk);
        #1;

        // Single zero byte, bit-serial: result exactly 8 cycles after accept.
        $display("[TB] single byte 00, latency");
        out_ready[0] = 1'b0;
        pushExp(0, 32'hD202_EF8D);
        applyStimulus(0, 8'h00, 1'b1, acc);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("lat_k%0d", k), {63'd0, out_valid[0]}, {63'd0, (k == 8)});
        end
        idleCycles(2);
        out_ready[0] = 1'b1;
        waitDrain(0);

        $display("[TB] single bytes 61 and FF");
        pushExp(0, 32'hE8B7_BE43);
        applyStimulus(0, 8'h61, 1'b1, acc);
        waitDrain(0);
        pushExp(0, 32'hFF00_0000);
        applyStimulus(0, 8'hFF, 1'b1, acc);
        waitDrain(0);

        // Random multi-word message with gaps long enough to drop to IDLE.
        $display("[TB] random message with gaps, bit-serial");
        for (int i = 0; i < 5; i++) rmsg.push_back(8'($urandom_range(0, 255)));
        pushExp(0, crcModel(rmsg));
        sendMessage(0, rmsg, 12, first, last);
        waitDrain(0);

        // Byte-wide folding, back-to-back: one accept per cycle.
        $display("[TB] 123456789 back-to-back, byte-wide");
        pushExp(1, 32'hCBF4_3926);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, msg9[i], (i == 8), acc);
            if (i == 0) first = acc;
            checkOutput($sformatf("b2b_acc%0d", i), 64'(acc), 64'(first + i));
        end
        checkOutput("b2b_valid_early", {63'd0, out_valid[1]}, 64'd0);
        @(posedge clk);
        #1;
        checkOutput("b2b_latency", 64'(cyc - first), 64'd9);
        checkOutput("b2b_valid", {63'd0, out_valid[1]}, 64'd1);
        waitDrain(1);

        // Random input gaps and a stalled consumer.
        $display("[TB] 123456789 with gaps and stalled output");
        out_ready[1] = 1'b0;
        pushExp(1, 32'hCBF4_3926);
        sendMessage(1, msg9, 3, first, last);
        begin
            int budget;
            budget = 50;
            while (!out_valid[1] && budget > 0) begin
                @(negedge clk);
                budget--;
            end
        end
        checkOutput("stall_valid_seen", {63'd0, out_valid[1]}, 64'd1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        out_ready[1] = 1'b1;
        waitDrain(1);

        // Reset in the middle of a bit-serial message, then a clean message.
        $display("[TB] reset mid-message");
        part = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 4; i++) applyStimulus(0, part[i], 1'b0, acc);
        idleCycles(3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkResetValues("midrst");
        @(posedge clk);
        #1;
        pushExp(0, 32'hCBF4_3926);
        sendMessage(0, msg9, 0, first, last);
        waitDrain(0);

        // Two consecutive messages: INIT must be reloaded in between.
        $display("[TB] two messages, byte-wide");
        pushExp(1, 32'hE8B7_BE43);
        pushExp(1, 32'hCBF4_3926);
        applyStimulus(1, 8'h61, 1'b1, acc);
        sendMessage(1, msg9, 0, first, last);
        waitDrain(1);

        idleCycles(4);
        checkOutput("final_q0", 64'(exp_q0.size()), 64'd0);
        checkOutput("final_q1", 64'(exp_q1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
